// File: rtl/pulse_event_logger.sv
// Pulse event logger: edge-detects pulse_in, stamps each event with a free-running cycle counter
// and queues the stamps in a first-word-fall-through FIFO. Define PULSE_LOG_DELTA_EN to store deltas.
module pulse_event_logger #(
  parameter int unsigned TS_W   = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DROP_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pulse_in,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [TS_W-1:0]        ev_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_cnt,
  input  logic                   clr_ovf
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] LevelFull = LvlW'(DEPTH);

  logic [TS_W-1:0]   ts_q;
  logic              pulse_prev_q;
  logic [TS_W-1:0]   mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q, level_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [TS_W-1:0]   push_val;
  logic              ev, full, pop, push, drop;

  assign ev   = pulse_in & ~pulse_prev_q;
  assign full = (level_q == LevelFull);
  assign pop  = ev_valid & ev_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push = ev & (~full | pop);
  assign drop = ev & full & ~pop;

`ifdef PULSE_LOG_DELTA_EN
  logic [TS_W-1:0] last_ts_q;

  assign push_val = ts_q - last_ts_q;

  // Updated on dropped events too, so deltas reflect true pulse spacing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ts_q <= '0;
    end else if (ev) begin
      last_ts_q <= ts_q;
    end
  end
`else
  assign push_val = ts_q;
`endif

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LvlW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LvlW'(1);
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = DROP_W'(drop);
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q         <= '0;
      pulse_prev_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      ts_q         <= ts_q + TS_W'(1);
      pulse_prev_q <= pulse_in;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else if (push) begin
      mem_q[wr_ptr_q] <= push_val;
    end
  end

  assign ev_valid = (level_q != '0);
  assign ev_data  = mem_q[rd_ptr_q];
  assign level    = level_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_pulse_event_logger.sv
// Self-checking bench for pulse_event_logger: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_pulse_event_logger;

  localparam int unsigned TS_W   = 16;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned DROP_W = 8;
  localparam int unsigned LvlW   = $clog2(DEPTH) + 1;
`ifdef PULSE_LOG_DELTA_EN
  localparam bit Delta = 1'b1;
`else
  localparam bit Delta = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pulse_in = 1'b0;
  logic              ev_ready = 1'b0;
  logic              clr_ovf = 1'b0;
  logic              ev_valid;
  logic [TS_W-1:0]   ev_data;
  logic [LvlW-1:0]   level;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;

  int n_checks = 0;
  int n_pass = 0;

  pulse_event_logger #(
    .TS_W  (TS_W),
    .DEPTH (DEPTH),
    .DROP_W(DROP_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pulse_in(pulse_in),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_data (ev_data),
    .level   (level),
    .overflow(overflow),
    .drop_cnt(drop_cnt),
    .clr_ovf (clr_ovf)
  );

  always #5 clk = ~clk;

  // Reference model: cycle count, previous input, queue of stored values, drop bookkeeping.
  logic [TS_W-1:0]   m_ts;
  logic              m_prev;
  logic [TS_W-1:0]   m_last;
  logic [TS_W-1:0]   m_q[$];
  logic              m_ovf;
  logic [DROP_W-1:0] m_drop;

  task automatic model_reset();
    m_ts = '0;
    m_prev = 1'b0;
    m_last = '0;
    m_q.delete();
    m_ovf = 1'b0;
    m_drop = '0;
  endtask

  task automatic model_step();
    bit is_ev, was_full, do_pop, dropped;
    logic [TS_W-1:0] val;
    is_ev = pulse_in && !m_prev;
    was_full = (m_q.size() == DEPTH);
    do_pop = (m_q.size() != 0) && ev_ready;
    dropped = 1'b0;
    val = Delta ? m_ts - m_last : m_ts;
    if (do_pop) void'(m_q.pop_front());
    if (is_ev) begin
      m_last = m_ts;
      if (!was_full || do_pop) m_q.push_back(val);
      else dropped = 1'b1;
    end
    if (clr_ovf) begin
      m_ovf = 1'b0;
      m_drop = dropped ? DROP_W'(1) : '0;
    end else if (dropped) begin
      m_ovf = 1'b1;
      if (m_drop != '1) m_drop = m_drop + DROP_W'(1);
    end
    m_prev = pulse_in;
    m_ts = m_ts + TS_W'(1);
  endtask

  // Advance one clock; ends on the falling edge where outputs are sampled and inputs driven.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pulse_in = 1'b0;
    ev_ready = 1'b0;
    clr_ovf = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ts(input logic [TS_W-1:0] t);
    while (m_ts != t) tick();
  endtask

  task automatic pulse_at(input logic [TS_W-1:0] t);
    wait_ts(t);
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (ev_valid !== 1'b0 || level !== '0 || overflow !== 1'b0 || drop_cnt !== '0 ||
        ev_data !== '0)
      $display("FAIL reset: valid=%b level=%0d ovf=%b drop=%0d data=%0d want all zero",
               ev_valid, level, overflow, drop_cnt, ev_data);
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    wait_ts(5);
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    n_checks++;
    if (ev_valid !== 1'b1 || ev_data !== 16'd5 || level !== LvlW'(1))
      $display("FAIL single_push: valid=%b data=%0d level=%0d want 1 5 1", ev_valid, ev_data, level);
    else n_pass++;
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    n_checks++;
    if (ev_valid !== 1'b0 || level !== '0)
      $display("FAIL single_pop: valid=%b level=%0d want 0 0", ev_valid, level);
    else n_pass++;
  endtask

  task automatic test_held();
    do_reset();
    wait_ts(10);
    pulse_in = 1'b1;
    repeat (5) tick();
    pulse_in = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (level !== LvlW'(1) || ev_data !== 16'd10)
      $display("FAIL held_pulse: level=%0d data=%0d want 1 10", level, ev_data);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [TS_W-1:0] exp_v [3];
    do_reset();
    exp_v[0] = 16'd20;
    exp_v[1] = Delta ? 16'd2 : 16'd22;
    exp_v[2] = Delta ? 16'd2 : 16'd24;
    pulse_at(20);
    pulse_at(22);
    pulse_at(24);
    n_checks++;
    if (level !== LvlW'(3))
      $display("FAIL b2b_level: got %0d want 3", level);
    else n_pass++;
    ev_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ev_valid !== 1'b1 || ev_data !== exp_v[i])
        $display("FAIL b2b_data[%0d]: valid=%b data=%0d want 1 %0d", i, ev_valid, ev_data, exp_v[i]);
      else n_pass++;
      tick();
    end
    ev_ready = 1'b0;
    n_checks++;
    if (ev_valid !== 1'b0)
      $display("FAIL b2b_empty: valid=%b want 0", ev_valid);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [TS_W-1:0] e;
    do_reset();
    for (int i = 0; i < 10; i++) pulse_at(TS_W'(2 + 2 * i));
    n_checks++;
    if (level !== LvlW'(8) || overflow !== 1'b1 || drop_cnt !== DROP_W'(2))
      $display("FAIL ovf_state: level=%0d ovf=%b drop=%0d want 8 1 2", level, overflow, drop_cnt);
    else n_pass++;
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_checks++;
    if (level !== LvlW'(8) || overflow !== 1'b0 || drop_cnt !== '0)
      $display("FAIL ovf_clear: level=%0d ovf=%b drop=%0d want 8 0 0", level, overflow, drop_cnt);
    else n_pass++;
    ev_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e = Delta ? 16'd2 : TS_W'(2 + 2 * i);
      n_checks++;
      if (ev_data !== e)
        $display("FAIL ovf_retained[%0d]: got %0d want %0d", i, ev_data, e);
      else n_pass++;
      tick();
    end
    ev_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [TS_W-1:0] e;
    do_reset();
    for (int i = 0; i < 8; i++) pulse_at(TS_W'(2 + 2 * i));
    wait_ts(30);
    pulse_in = 1'b1;
    ev_ready = 1'b1;
    tick();
    pulse_in = 1'b0;
    ev_ready = 1'b0;
    n_checks++;
    if (level !== LvlW'(8) || drop_cnt !== '0 || overflow !== 1'b0)
      $display("FAIL full_pushpop: level=%0d drop=%0d ovf=%b want 8 0 0", level, drop_cnt, overflow);
    else n_pass++;
    ev_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) e = Delta ? 16'd14 : 16'd30;
      else e = Delta ? 16'd2 : TS_W'(4 + 2 * i);
      n_checks++;
      if (ev_data !== e)
        $display("FAIL full_order[%0d]: got %0d want %0d", i, ev_data, e);
      else n_pass++;
      tick();
    end
    ev_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    pulse_at(2);
    pulse_at(4);
    pulse_at(6);
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (ev_valid !== 1'b0 || level !== '0)
      $display("FAIL midreset_async: valid=%b level=%0d want 0 0", ev_valid, level);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulse_at(3);
    n_checks++;
    if (ev_valid !== 1'b1 || level !== LvlW'(1) || ev_data !== 16'd3)
      $display("FAIL midreset_restart: valid=%b level=%0d data=%0d want 1 1 3",
               ev_valid, level, ev_data);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [TS_W-1:0] e;
    do_reset();
    pulse_at(16'hFFFF);
    pulse_at(16'd1);
    e = Delta ? 16'd2 : 16'd1;
    n_checks++;
    if (level !== LvlW'(2) || ev_data !== 16'hFFFF)
      $display("FAIL wrap_head: level=%0d data=%h want 2 ffff", level, ev_data);
    else n_pass++;
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    n_checks++;
    if (ev_data !== e)
      $display("FAIL wrap_second: got %0d want %0d", ev_data, e);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [TS_W-1:0] exp_data;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      pulse_in = 1'($urandom_range(0, 1));
      if (c < 1000) ev_ready = ($urandom_range(0, 3) != 0);
      else if (c < 2500) ev_ready = 1'b0;
      else ev_ready = ($urandom_range(0, 3) == 0);
      clr_ovf = (c < 1000 || c >= 2500) && ($urandom_range(0, 40) == 0);
      tick();
      exp_data = (m_q.size() != 0) ? m_q[0] : ev_data;
      n_checks++;
      if (ev_valid !== (m_q.size() != 0) || level !== LvlW'(m_q.size()) || overflow !== m_ovf ||
          drop_cnt !== m_drop || ev_data !== exp_data)
        $display("FAIL random[%0d]: valid=%b level=%0d ovf=%b drop=%0d data=%0d want %b %0d %b %0d %0d",
                 c, ev_valid, level, overflow, drop_cnt, ev_data, (m_q.size() != 0), m_q.size(),
                 m_ovf, m_drop, exp_data);
      else n_pass++;
    end
    pulse_in = 1'b0;
    ev_ready = 1'b0;
    clr_ovf = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_held();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_mid_reset();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pulse_event_logger.md
Name: pulse_event_logger

Overview:
- Sits directly downstream of the debounce/pulse filter stage and consumes its one-cycle `pulse_out` as `pulse_in`.
- Stamps each detected pulse with a free-running cycle timestamp and buffers the stamps in a small FIFO.
- A consumer drains the FIFO over a valid/ready handshake.
- Flags and counts events lost to a full FIFO.

Parameters:
- TS_W, 16, timestamp counter width in bits; wraps modulo 2^TS_W.
- DEPTH, 8, FIFO entries; must be a power of two, at least 2.
- DROP_W, 8, width of the saturating dropped-event counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pulse_in  input  1  filtered event pulse from the upstream filter stage.
- ev_valid  output  1  FIFO non-empty; ev_data is valid.
- ev_ready  input  1  consumer accepts head entry when ev_valid && ev_ready.
- ev_data  output  TS_W  timestamp (or delta, see Optional Feature) of the head entry.
- level  output  $clog2(DEPTH)+1  current number of stored entries.
- overflow  output  1  sticky flag: at least one event was dropped.
- drop_cnt  output  DROP_W  dropped events, saturating at all-ones.
- clr_ovf  input  1  synchronous clear of overflow and drop_cnt.

Behaviour:
- Clock and reset: one clock domain (clk); reset rst_n is asynchronous and active-low.
- Reset values: ts=0, ev_valid=0, level=0, overflow=0, drop_cnt=0, ev_data=0 (read of a cleared slot). The FIFO is emptied; the edge-detect register pulse_d=0.
- Reset asserted mid-operation: all stored entries are discarded immediately; nothing is replayed after release.
- Timestamp counter ts: increments by 1 every clock after reset; wraps from 2^TS_W-1 to 0 with no flag.
- Event detect: event = pulse_in && !pulse_d, where pulse_d is pulse_in registered.
  - A pulse held high for several cycles counts once.
  - Back-to-back pulses separated by one low cycle count twice.
- Push: on an event in cycle N, the value of ts in cycle N is written at the end of cycle N.
  - Latency: ev_valid is high in cycle N+1 if the FIFO was empty.
- Pop: when ev_valid && ev_ready, the head entry is removed at the clock edge.
  - ev_data is first-word-fall-through: it always shows the head entry while ev_valid=1, and is undefined/don't-care when ev_valid=0.
- ev_data is stable while ev_valid=1 and ev_ready=0.
- Pointers: wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally. level tracks occupancy, 0..DEPTH.
- Simultaneous push and pop:
  - Not full: both occur; level is unchanged.
  - Full: the pop frees a slot and the push is accepted; no drop.
  - Empty: no pop is possible; the push occurs.
- Full, with no pop in the same cycle: the event is dropped.
  - overflow<=1.
  - drop_cnt<=drop_cnt+1, unless already all-ones.
  - FIFO contents are unchanged.
- clr_ovf=1: overflow<=0 and drop_cnt<=0.
  - If a drop coincides with clr_ovf, the clear wins for overflow; drop_cnt<=1 records the coincident drop.
- ev_ready while ev_valid=0 has no effect.

Optional Feature:
- Macro: PULSE_LOG_DELTA_EN.
- Defined:
  - Each pushed value is (ts - last_ts) mod 2^TS_W, where last_ts is a TS_W register.
  - last_ts resets to 0 and updates to ts on every detected event, including dropped ones, so deltas always reflect true pulse spacing.
  - The first event after reset therefore stores its absolute ts.
- Not defined: absolute ts values are pushed and no last_ts register exists.

Test Plan:
- Reset, then hold pulse_in low; drive 1 in the ts=5 cycle, 0 otherwise; ev_ready=0 → ev_valid=1 from the next cycle, ev_data=5, level=1; ev_ready=1 for one cycle → ev_valid=0, level=0.
- pulse_in high for ts=10..14 (five cycles) → exactly one entry, ev_data=10.
- Pulses at ts=20,22,24 (one-cycle, one low between), ev_ready=0 → level=3; drain → ev_data 20,22,24 in order.
  - With PULSE_LOG_DELTA_EN: 20,2,2.
- ev_ready=0, DEPTH=8: apply 10 separated pulses → level=8, overflow=1, drop_cnt=2, first 8 stamps retained; pulse clr_ovf → overflow=0, drop_cnt=0, level=8.
- FIFO full, ev_ready=1 in the same cycle as a new event → level stays 8, drop_cnt unchanged, newest stamp lands at tail.
- Fill 3 entries, assert rst_n low mid-stream for 2 cycles → ev_valid=0, level=0 immediately; after release ts restarts at 0 and a pulse at ts=3 yields ev_data=3.
